// File: rtl/vend_change_ctrl.sv
// Newspaper kiosk vending sequencer: accumulates 5c/10c credit, vends at a
// programmable price, returns over-payment as 5c change pulses, tracks stock.
module vend_change_ctrl #(
  parameter int unsigned PRICE_UNITS = 3,
  parameter int unsigned STOCK_W     = 4,
  parameter int unsigned STOCK_INIT  = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         coin,
  input  logic               cancel,
  input  logic               restock,
  output logic               newspaper,
  output logic               change_coin,
  output logic               coin_reject,
  output logic [2:0]         credit,
  output logic [STOCK_W-1:0] stock,
  output logic               empty,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    VEND,
    REFUND
  } state_t;

  localparam logic [2:0]         PRICE        = 3'(PRICE_UNITS);
  localparam logic [STOCK_W-1:0] STOCK_RELOAD = STOCK_W'(STOCK_INIT);

  state_t               state;
  state_t               state_nxt;
  logic [2:0]           credit_nxt;
  logic [STOCK_W-1:0]   stock_nxt;
  logic                 reject_nxt;

  logic [2:0]           coin_value;
  logic                 coin_legal;
  logic                 coin_present;
  logic                 open_state;
  logic                 cancel_taken;
  logic                 coin_taken;
  logic [2:0]           credit_sum;
  logic [2:0]           credit_left;

  always_comb begin
    coin_value = '0;
    coin_legal = 1'b0;
    case (coin)
      2'b01: begin
        coin_value = 3'd1;
        coin_legal = 1'b1;
      end
      2'b10: begin
        coin_value = 3'd2;
        coin_legal = 1'b1;
      end
      default: begin
        coin_value = '0;
        coin_legal = 1'b0;
      end
    endcase
  end

  // Any coin that is not taken into credit goes straight back to the buyer.
  assign coin_present = (coin != 2'b00);
  assign open_state   = (state == IDLE) || (state == COLLECT);
  assign cancel_taken = (state == COLLECT) && cancel;
  assign coin_taken   = open_state && !empty && !cancel && coin_legal;
  assign credit_sum   = credit + coin_value;
  assign credit_left  = credit - PRICE;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      credit      <= '0;
      stock       <= STOCK_RELOAD;
      coin_reject <= 1'b0;
    end else begin
      state       <= state_nxt;
      credit      <= credit_nxt;
      stock       <= stock_nxt;
      coin_reject <= reject_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    credit_nxt = credit;
    stock_nxt  = stock;
    reject_nxt = coin_present && !coin_taken;
    case (state)
      IDLE, COLLECT: begin
        if (cancel_taken) begin
          state_nxt = REFUND;
        end else if (coin_taken) begin
          credit_nxt = credit_sum;
          state_nxt  = (credit_sum >= PRICE) ? VEND : COLLECT;
        end
        if ((state == IDLE) && restock) begin
          stock_nxt = STOCK_RELOAD;
        end
      end
      VEND: begin
        credit_nxt = credit_left;
        stock_nxt  = stock - 1'b1;
        state_nxt  = (credit_left != '0) ? REFUND : IDLE;
      end
      REFUND: begin
        credit_nxt = (credit != '0) ? credit - 1'b1 : '0;
        state_nxt  = (credit <= 3'd1) ? IDLE : REFUND;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    newspaper   = (state == VEND);
    change_coin = (state == REFUND);
    busy        = (state == VEND) || (state == REFUND);
  end

  assign empty = (stock == '0);

endmodule

// File: tb/tb_vend_change_ctrl.sv
// Scoreboard bench for vend_change_ctrl: a transaction-level kiosk model
// predicts every cycle's outputs; a monitor pops and compares each negedge.
module tb_vend_change_ctrl;

  localparam int PRICE = 3;
  localparam int SW    = 4;
  localparam int SINIT = 10;

  logic          clock   = 1'b0;
  logic          reset   = 1'b1;
  logic [1:0]    coin    = 2'b00;
  logic          cancel  = 1'b0;
  logic          restock = 1'b0;
  logic          newspaper;
  logic          change_coin;
  logic          coin_reject;
  logic [2:0]    credit;
  logic [SW-1:0] stock;
  logic          empty;
  logic          busy;

  vend_change_ctrl #(
    .PRICE_UNITS(PRICE),
    .STOCK_W    (SW),
    .STOCK_INIT (SINIT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .coin       (coin),
    .cancel     (cancel),
    .restock    (restock),
    .newspaper  (newspaper),
    .change_coin(change_coin),
    .coin_reject(coin_reject),
    .credit     (credit),
    .stock      (stock),
    .empty      (empty),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic          newspaper;
    logic          change_coin;
    logic          coin_reject;
    logic [2:0]    credit;
    logic [SW-1:0] stock;
    logic          empty;
    logic          busy;
  } obs_t;

  typedef struct {
    obs_t  o;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_bad  = 0;
  bit   mon_on = 1'b0;

  // Kiosk model: money held, papers held, and whether a sale or a change
  // payout is in progress.
  int m_credit;
  int m_stock;
  bit m_vend;
  bit m_refund;

  function automatic obs_t make_obs(bit np, bit ch, bit rj, int cr, int st);
    obs_t o;
    o.newspaper   = np;
    o.change_coin = ch;
    o.coin_reject = rj;
    o.credit      = 3'(cr);
    o.stock       = SW'(st);
    o.empty       = (st == 0);
    o.busy        = np | ch;
    return o;
  endfunction

  function automatic obs_t sample_dut();
    obs_t o;
    o.newspaper   = newspaper;
    o.change_coin = change_coin;
    o.coin_reject = coin_reject;
    o.credit      = credit;
    o.stock       = stock;
    o.empty       = empty;
    o.busy        = busy;
    return o;
  endfunction

  task automatic check(input string tag, input obs_t got, input obs_t want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got np=%0b ch=%0b rj=%0b cr=%0d st=%0d em=%0b bz=%0b, expected np=%0b ch=%0b rj=%0b cr=%0d st=%0d em=%0b bz=%0b",
               tag, $time, got.newspaper, got.change_coin, got.coin_reject, got.credit,
               got.stock, got.empty, got.busy, want.newspaper, want.change_coin,
               want.coin_reject, want.credit, want.stock, want.empty, want.busy);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clock or posedge reset);
      if (mon_on) begin
        if (reset) begin
          #1;
          check("async_reset", sample_dut(), make_obs(0, 0, 0, 0, SINIT));
        end else if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check(e.tag, sample_dut(), e.o);
        end
      end
    end
  end

  task automatic model_reset();
    m_credit = 0;
    m_stock  = SINIT;
    m_vend   = 1'b0;
    m_refund = 1'b0;
  endtask

  task automatic push_idle(input string tag);
    exp_t e;
    e.o   = make_obs(0, 0, 0, m_credit, m_stock);
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // One clock of stimulus; the model predicts what is visible after the edge.
  task automatic step(input logic [1:0] c, input bit can, input bit rs, input string tag);
    int   val;
    int   nc;
    int   ns;
    bit   nv;
    bit   nr;
    bit   rj;
    exp_t e;
    @(negedge clock);
    #1;
    coin    = c;
    cancel  = can;
    restock = rs;
    val = (c == 2'b01) ? 1 : (c == 2'b10) ? 2 : 0;
    nc  = m_credit;
    ns  = m_stock;
    nv  = 1'b0;
    nr  = 1'b0;
    rj  = 1'b0;
    if (m_vend) begin
      nc = m_credit - PRICE;
      ns = m_stock - 1;
      nr = (nc > 0);
      rj = (c != 2'b00);
    end else if (m_refund) begin
      nc = m_credit - 1;
      nr = (nc > 0);
      rj = (c != 2'b00);
    end else begin
      if (can && m_credit > 0) begin
        nr = 1'b1;
        rj = (c != 2'b00);
      end else if (val > 0 && m_stock > 0 && !can) begin
        nc = m_credit + val;
        nv = (nc >= PRICE);
      end else begin
        rj = (c != 2'b00);
      end
      if (rs && m_credit == 0) ns = SINIT;
    end
    m_credit = nc;
    m_stock  = ns;
    m_vend   = nv;
    m_refund = nr;
    e.o   = make_obs(nv, nr, rj, nc, ns);
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic sale15(input string tag);
    step(2'b10, 0, 0, tag);
    step(2'b01, 0, 0, tag);
    step(2'b00, 0, 0, tag);
  endtask

  initial begin
    int r;
    logic [1:0] c;
    model_reset();
    repeat (2) @(negedge clock);
    #1;
    reset  = 1'b0;
    mon_on = 1'b1;
    push_idle("post_reset");

    // Exact price: 10c + 5c, single newspaper, no change.
    step(2'b10, 0, 0, "exact_c10");
    step(2'b01, 0, 0, "exact_c5");
    step(2'b00, 0, 0, "exact_vend");
    step(2'b00, 0, 0, "exact_idle");

    // Over-payment: 10c + 10c, then one change pulse.
    step(2'b10, 0, 0, "over_c10a");
    step(2'b10, 0, 0, "over_c10b");
    step(2'b00, 0, 0, "over_vend");
    step(2'b00, 0, 0, "over_change");
    step(2'b00, 0, 0, "over_idle");

    // Cancel beats a coin in the same cycle.
    step(2'b01, 0, 0, "cancel_c5");
    step(2'b10, 1, 0, "cancel_with_c10");
    step(2'b00, 0, 0, "cancel_refund");
    step(2'b00, 0, 0, "cancel_idle");

    // Illegal code in IDLE; coin during VEND.
    step(2'b11, 0, 0, "reject_code11");
    step(2'b00, 0, 0, "reject_after11");
    step(2'b10, 0, 0, "vendrej_c10");
    step(2'b01, 0, 0, "vendrej_c5");
    step(2'b01, 0, 0, "vendrej_in_vend");
    step(2'b00, 0, 0, "vendrej_idle");

    // Sell out, reject while empty, restock, restock ignored in VEND.
    while (m_stock > 0) sale15("sellout");
    step(2'b01, 0, 0, "empty_c5");
    step(2'b00, 0, 0, "empty_idle");
    step(2'b00, 0, 1, "restock_idle");
    step(2'b10, 0, 0, "rsvend_c10");
    step(2'b01, 0, 0, "rsvend_c5");
    step(2'b00, 0, 1, "rsvend_restock");
    step(2'b00, 0, 0, "rsvend_idle");

    // Asynchronous reset between edges with credit held.
    step(2'b10, 0, 0, "midrst_c10");
    @(negedge clock);
    #1;
    coin = 2'b00;
    #1;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
    push_idle("midrst_after");
    step(2'b00, 0, 0, "midrst_idle1");
    step(2'b00, 0, 0, "midrst_idle2");

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 7);
      c = (r < 3) ? 2'b00 : (r < 5) ? 2'b01 : (r < 7) ? 2'b10 : 2'b11;
      step(c, ($urandom_range(0, 7) == 0), ($urandom_range(0, 29) == 0), "random");
    end
    for (int i = 0; i < 8; i++) step(2'b00, 0, 0, "drain");
    repeat (2) @(negedge clock);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vend_change_ctrl.md
Name: vend_change_ctrl

Overview:
- Full vending sequencer for the newspaper kiosk: accumulates 5c/10c coins into a credit register, vends when credit reaches a programmable price, and returns over-payment as a train of 5c change pulses.
- Also handles buyer cancel/refund, reject of illegal or untimely coins, and a stock counter with restock.
- Sits between the coin acceptor and the dispenser/change-hopper drivers.

Parameters:
- PRICE_UNITS, 3, price in 5c units; legal range 1..6.
- STOCK_W, 4, stock counter width.
- STOCK_INIT, 10, stock value loaded on reset and restock; must be <= 2^STOCK_W-1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- coin  in  2  coin code, sampled every edge: 00 none, 01 5c, 10 10c, 11 invalid.
- cancel  in  1  buyer refund request, level sampled each edge.
- restock  in  1  reload stock to STOCK_INIT.
- newspaper  out  1  dispense strobe, one cycle per sale.
- change_coin  out  1  one 5c coin returned per high cycle.
- coin_reject  out  1  registered one-cycle pulse; coin sampled at the previous edge is returned.
- credit  out  3  current credit in 5c units.
- stock  out  STOCK_W  papers remaining.
- empty  out  1  stock == 0 (combinational).
- busy  out  1  state is VEND or REFUND.

Behaviour:
- Reset (async) values:
  - state IDLE; credit 0; stock STOCK_INIT.
  - coin_reject 0; newspaper, change_coin and busy 0.
  - Credit held at reset is lost; no refund is issued.
- States: IDLE (credit 0), COLLECT (0 < credit < PRICE_UNITS), VEND, REFUND.
- newspaper = (state==VEND); change_coin = (state==REFUND). Both are Moore decodes of registered state.
- Coin acceptance:
  - Accepted only in IDLE/COLLECT with empty==0 and cancel==0.
  - Value 1 unit (01) or 2 units (10). Credit is updated at that edge.
  - If the new credit >= PRICE_UNITS, next state is VEND; otherwise COLLECT.
- Coin rejection:
  - Code 11, any nonzero coin while VEND/REFUND, any nonzero coin while empty, or any nonzero coin in a cycle where cancel is honoured.
  - Effect: coin_reject=1 for exactly the next cycle; credit unchanged.
- Cancel:
  - Honoured only in COLLECT; has priority over a coin in the same cycle. Next state is REFUND with credit held.
  - Ignored in IDLE, VEND and REFUND.
- VEND (exactly one cycle):
  - newspaper=1. On leaving: stock -= 1, credit -= PRICE_UNITS.
  - Next state is REFUND if the remaining credit is > 0, else IDLE.
- REFUND:
  - Each cycle change_coin=1 and credit decrements by 1 at the closing edge.
  - The edge that brings credit to 0 moves to IDLE.
  - Total change pulses equal the credit on entry.
- Restock:
  - Honoured only in IDLE: stock <= STOCK_INIT. Ignored elsewhere, so no race with the VEND decrement.
- Empty:
  - Stock can only reach 0 via VEND. After that, coins are rejected until restock.
  - Credit collected before the sale that empties stock is unaffected.
- Width rules:
  - Max credit = PRICE_UNITS-1+2 <= 7, which fits 3 bits.
  - Stock never underflows, because VEND is unreachable with stock 0.
- Latency: sale completes with newspaper high 1 cycle after the price-reaching coin edge. Change begins the cycle after VEND.

Test Plan:
- Reset, then coin 10 at edge 1 and coin 5 at edge 2 (PRICE_UNITS=3) -> credit 2 then 3. newspaper high for exactly cycle 3, change_coin never high. credit 0, stock 9, state IDLE.
- Coin 10 then coin 10 -> credit 4, one newspaper pulse, then exactly one change_coin pulse, then IDLE with credit 0.
- Coin 5, then cancel asserted together with coin 10 -> coin_reject pulse next cycle, one change_coin pulse, no newspaper, credit 0.
- Coin code 11 in IDLE, and coin 5 applied during VEND -> one coin_reject pulse each, credit and state unaffected.
- Ten back-to-back 15c sales -> stock 0, empty=1. A further coin 5 is rejected. restock in IDLE -> stock 10, empty=0. restock asserted during VEND is ignored.
- Coin 10, then reset asserted mid-cycle (asynchronously, between edges) -> outputs clear immediately: credit 0, stock 10, no change pulses after release.
